// File: rtl/insight_trace_pkg.sv
`default_nettype none
// ============================================================================
// insight_trace_pkg
//   Shared record, kind and hart-state types for the Insight retirement trace.
//   Revision: 1.0
// ============================================================================
package insight_trace_pkg;

  localparam int PKG_XLEN = 32;

  typedef enum logic [1:0] {
    COMMIT    = 2'd0,
    EXCEPTION = 2'd1,
    INTERRUPT = 2'd2
  } rec_kind_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WFI    = 2'd1,
    CEASED = 2'd2
  } hart_state_e;

  typedef struct packed {
    rec_kind_e           kind;
    logic [PKG_XLEN-1:0] pc;
    logic [31:0]         insn;
    logic                wb;
    logic [4:0]          rd;
    logic [PKG_XLEN-1:0] data;
    logic [31:0]         seq;
  } commit_rec_t;

endpackage
`default_nettype wire

// File: rtl/insight_rec_fifo.sv
`default_nettype none
// ============================================================================
// insight_rec_fifo
//   Registered record FIFO with wrap-bit pointers; push while full is legal
//   only together with a pop.
//   Revision: 1.0
// ============================================================================
module insight_rec_fifo
  import insight_trace_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = commit_rec_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
    $error("insight_rec_fifo: DEPTH must be a power of two >= 2");
  end

  T            mem_q [DEPTH];
  T            mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/insight_commit_tracker.sv
`default_nettype none
// ============================================================================
// insight_commit_tracker
//   Arbitrates Insight retirement events into sequence-numbered FIFO records,
//   tracks hart run/WFI/cease state, drop statistics and a hang watchdog.
//   Revision: 1.0
// ============================================================================
module insight_commit_tracker
  import insight_trace_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            commit,
  input  logic            exception,
  input  logic            interrupt_fire,
  input  logic            wfi,
  input  logic            cease,
  input  logic [XLEN-1:0] ev_pc,
  input  logic [31:0]     ev_insn,
  input  logic [XLEN-1:0] ev_cause,
  input  logic            ev_wb,
  input  logic [4:0]      ev_rd,
  input  logic [XLEN-1:0] ev_data,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [1:0]      rec_kind,
  output logic [XLEN-1:0] rec_pc,
  output logic [31:0]     rec_insn,
  output logic [XLEN-1:0] rec_data,
  output logic            rec_wb,
  output logic [4:0]      rec_rd,
  output logic [31:0]     rec_seq,
  output logic [63:0]     retire_count,
  output logic [15:0]     drop_count,
  output logic            overflow,
  output logic            collision,
  output logic            hang,
  output logic [1:0]      state
);

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  if (XLEN != PKG_XLEN) begin : g_xlen_check
    $error("insight_commit_tracker: XLEN must match PKG_XLEN");
  end

  hart_state_e     state_q, state_d;
  logic [31:0]     seq_q, seq_d;
  logic [63:0]     retire_q, retire_d;
  logic [15:0]     drop_q, drop_d;
  logic            overflow_q, overflow_d;
  logic            collision_q, collision_d;
  logic            hang_q, hang_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic            fifo_full, fifo_empty, push, pop, any_ev, ceased;
  logic [1:0]      n_ev;
  logic [16:0]     drop_sum;
  commit_rec_t     push_rec, head_rec;

  assign pop = !fifo_empty && rec_ready;

  always_comb begin
    push_rec      = '0;
    push_rec.pc   = ev_pc;
    push_rec.insn = ev_insn;
    push_rec.seq  = seq_q;
    if (interrupt_fire) begin
      push_rec.kind = INTERRUPT;
      push_rec.data = ev_cause;
    end else if (exception) begin
      push_rec.kind = EXCEPTION;
      push_rec.data = ev_cause;
    end else begin
      push_rec.kind = COMMIT;
      push_rec.wb   = ev_wb;
      push_rec.rd   = ev_rd;
      push_rec.data = ev_data;
    end

    n_ev   = {1'b0, commit} + {1'b0, exception} + {1'b0, interrupt_fire};
    any_ev = (n_ev != 2'd0);
    ceased = (state_q == CEASED);
    // A full FIFO still accepts when the head leaves in the same cycle.
    push   = any_ev && !ceased && (!fifo_full || pop);

    state_d = state_q;
    if (!ceased) begin
      if (cease) state_d = CEASED;
      else if (state_q == RUN && wfi) state_d = WFI;
      else if (state_q == WFI && !wfi) state_d = RUN;
    end

    seq_d    = push ? seq_q + 32'd1 : seq_q;
    retire_d = (push && push_rec.kind == COMMIT) ? retire_q + 64'd1 : retire_q;

    // Every asserted event that does not become a record is a drop.
    drop_sum    = {1'b0, drop_q} + {15'd0, n_ev} - {16'd0, push};
    drop_d      = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d  = overflow_q | (any_ev && !ceased && !push);
    collision_d = collision_q | (!ceased && (n_ev > 2'd1));

    wd_d = wd_q;
    if (state_q == RUN) begin
      if (any_ev || state_d == WFI) wd_d = '0;
      else if (wd_q != WD_MAX)      wd_d = wd_q + WD_W'(1);
    end
    hang_d = hang_q | (wd_d == WD_MAX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      seq_q       <= '0;
      retire_q    <= '0;
      drop_q      <= '0;
      overflow_q  <= 1'b0;
      collision_q <= 1'b0;
      hang_q      <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      retire_q    <= retire_d;
      drop_q      <= drop_d;
      overflow_q  <= overflow_d;
      collision_q <= collision_d;
      hang_q      <= hang_d;
      wd_q        <= wd_d;
    end
  end

  insight_rec_fifo #(
    .DEPTH (DEPTH),
    .T     (commit_rec_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .rd_data   (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rec_valid    = !fifo_empty;
  assign rec_kind     = head_rec.kind;
  assign rec_pc       = head_rec.pc;
  assign rec_insn     = head_rec.insn;
  assign rec_data     = head_rec.data;
  assign rec_wb       = head_rec.wb;
  assign rec_rd       = head_rec.rd;
  assign rec_seq      = head_rec.seq;
  assign retire_count = retire_q;
  assign drop_count   = drop_q;
  assign overflow     = overflow_q;
  assign collision    = collision_q;
  assign hang         = hang_q;
  assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_insight_commit_tracker.sv
`default_nettype none
// ============================================================================
// tb_insight_commit_tracker
//   Randomized and directed stimulus checked against a queue-based model.
//   Revision: 1.0
// ============================================================================
module tb_insight_commit_tracker;

  localparam int DEPTH   = 8;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4096;
  localparam int ST_RUN = 0, ST_WFI = 1, ST_CEASED = 2;

  typedef logic [135:0] w_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            commit, exception, interrupt_fire, wfi, cease, ev_wb, rec_ready;
  logic [XLEN-1:0] ev_pc, ev_cause, ev_data;
  logic [31:0]     ev_insn;
  logic [4:0]      ev_rd;
  logic            rec_valid, rec_wb, overflow, collision, hang;
  logic [1:0]      rec_kind, state;
  logic [XLEN-1:0] rec_pc, rec_data;
  logic [31:0]     rec_insn, rec_seq;
  logic [4:0]      rec_rd;
  logic [63:0]     retire_count;
  logic [15:0]     drop_count;

  insight_commit_tracker #(.DEPTH(DEPTH), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .commit(commit), .exception(exception),
    .interrupt_fire(interrupt_fire), .wfi(wfi), .cease(cease), .ev_pc(ev_pc),
    .ev_insn(ev_insn), .ev_cause(ev_cause), .ev_wb(ev_wb), .ev_rd(ev_rd),
    .ev_data(ev_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_kind(rec_kind), .rec_pc(rec_pc), .rec_insn(rec_insn), .rec_data(rec_data),
    .rec_wb(rec_wb), .rec_rd(rec_rd), .rec_seq(rec_seq), .retire_count(retire_count),
    .drop_count(drop_count), .overflow(overflow), .collision(collision),
    .hang(hang), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned kind;
    logic [31:0] pc, insn;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data, seq;
  } mrec_t;

  mrec_t           mq[$];
  int unsigned     m_seq;
  longint unsigned m_retire;
  int              m_drop, m_state, m_idle;
  bit              m_ovf, m_col, m_hang;
  int              vectors = 0;
  int              errors  = 0;

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic w_t dut_rec();
    return {rec_kind, rec_pc, rec_insn, rec_wb, rec_rd, rec_data, rec_seq};
  endfunction

  function automatic w_t pack(input mrec_t m);
    return {2'(m.kind), m.pc, m.insn, m.wb, m.rd, m.data, m.seq};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_seq = 0; m_retire = 0; m_drop = 0; m_state = ST_RUN; m_idle = 0;
    m_ovf = 0; m_col = 0; m_hang = 0;
  endtask

  task automatic model_step();
    int    n, ns;
    bit    pop, pushed;
    mrec_t r;
    n      = int'(commit) + int'(exception) + int'(interrupt_fire);
    pop    = (mq.size() != 0) && rec_ready;
    pushed = 0;
    ns     = m_state;
    if (m_state != ST_CEASED) ns = cease ? ST_CEASED : (wfi ? ST_WFI : ST_RUN);
    if (pop) void'(mq.pop_front());
    if (m_state != ST_CEASED && n > 0) begin
      if (mq.size() < DEPTH) begin
        r.kind = interrupt_fire ? 2 : (exception ? 1 : 0);
        r.pc   = ev_pc;
        r.insn = ev_insn;
        r.wb   = (r.kind == 0) ? ev_wb : 1'b0;
        r.rd   = (r.kind == 0) ? ev_rd : 5'd0;
        r.data = (r.kind == 0) ? ev_data : ev_cause;
        r.seq  = m_seq;
        m_seq++;
        if (r.kind == 0) m_retire++;
        mq.push_back(r);
        pushed = 1;
      end else begin
        m_ovf = 1;
      end
      if (n > 1) m_col = 1;
    end
    m_drop = m_drop + n - int'(pushed);
    if (m_drop > 65535) m_drop = 65535;
    if (m_state == ST_RUN) begin
      if (n > 0 || ns == ST_WFI) m_idle = 0;
      else if (m_idle < TIMEOUT) m_idle++;
      if (m_idle == TIMEOUT) m_hang = 1;
    end
    m_state = ns;
  endtask

  task automatic compare_all();
    chk("rec_valid", w_t'(rec_valid), w_t'(mq.size() != 0));
    if (mq.size() != 0) chk("rec_fields", dut_rec(), pack(mq[0]));
    chk("retire_count", w_t'(retire_count), w_t'(m_retire));
    chk("drop_count", w_t'(drop_count), w_t'(m_drop));
    chk("overflow", w_t'(overflow), w_t'(m_ovf));
    chk("collision", w_t'(collision), w_t'(m_col));
    chk("hang", w_t'(hang), w_t'(m_hang));
    chk("state", w_t'(state), w_t'(m_state));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic clr_inputs();
    commit = 0; exception = 0; interrupt_fire = 0; wfi = 0; cease = 0;
    ev_wb = 0; ev_rd = 0; ev_pc = 0; ev_insn = 0; ev_cause = 0; ev_data = 0;
    rec_ready = 0;
  endtask

  task automatic rand_fields();
    ev_pc = $urandom; ev_insn = $urandom; ev_cause = $urandom; ev_data = $urandom;
    ev_wb = 1'($urandom_range(0, 1)); ev_rd = 5'($urandom_range(0, 31));
  endtask

  task automatic do_reset();
    @(negedge clock);
    clr_inputs();
    reset = 1;
    #1;
    chk("async_reset_valid", w_t'(rec_valid), w_t'(0));
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    model_reset();
    compare_all();
    chk("reset_rec_zero", dut_rec(), w_t'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr_inputs();
    do_reset();

    // single commit
    commit = 1; ev_pc = 32'h8000_0000; ev_rd = 5; ev_data = 32'h1234; ev_wb = 1;
    ev_insn = $urandom; rec_ready = 1;
    tick();
    chk("t1_valid", w_t'(rec_valid), w_t'(1));
    chk("t1_kind", w_t'(rec_kind), w_t'(0));
    chk("t1_seq", w_t'(rec_seq), w_t'(0));
    chk("t1_pc", w_t'(rec_pc), w_t'(32'h8000_0000));
    chk("t1_retire", w_t'(retire_count), w_t'(1));
    commit = 0;
    tick();

    // commit + interrupt collision
    do_reset();
    rand_fields();
    commit = 1; interrupt_fire = 1; ev_cause = 32'h8000_0007; rec_ready = 1;
    tick();
    chk("t2_kind", w_t'(rec_kind), w_t'(2));
    chk("t2_data", w_t'(rec_data), w_t'(32'h8000_0007));
    chk("t2_collision", w_t'(collision), w_t'(1));
    chk("t2_drop", w_t'(drop_count), w_t'(1));
    clr_inputs();
    tick();

    // overflow then in-order drain
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rand_fields(); commit = 1;
      tick();
    end
    chk("t3_drop", w_t'(drop_count), w_t'(2));
    chk("t3_overflow", w_t'(overflow), w_t'(1));
    commit = 0; rec_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_seq_order", w_t'(rec_seq), w_t'(i));
      tick();
    end

    // push while full with simultaneous pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      rand_fields(); commit = 1;
      tick();
    end
    rand_fields(); rec_ready = 1;
    tick();
    chk("t4_drop", w_t'(drop_count), w_t'(0));
    commit = 0;
    for (int i = 0; i < DEPTH + 1; i++) tick();

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_fields();
      commit         = ($urandom_range(0, 99) < 50);
      exception      = ($urandom_range(0, 99) < 10);
      interrupt_fire = ($urandom_range(0, 99) < 10);
      rec_ready      = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 3) wfi = ~wfi;
      tick();
    end

    // drop_count saturation
    do_reset();
    commit = 1; exception = 1; interrupt_fire = 1;
    for (int i = 0; i < 21900; i++) begin
      rand_fields();
      tick();
    end
    chk("sat_drop", w_t'(drop_count), w_t'(16'hFFFF));
    clr_inputs();

    // WFI holds the watchdog, RUN idle trips it
    do_reset();
    wfi = 1;
    for (int i = 0; i < 10000; i++) tick();
    chk("t5_state_wfi", w_t'(state), w_t'(1));
    chk("t5_hang_wfi", w_t'(hang), w_t'(0));
    wfi = 0;
    for (int i = 0; i < 4097; i++) tick();
    chk("t5_hang", w_t'(hang), w_t'(1));

    // cease with queued records
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_fields(); commit = 1;
      tick();
    end
    commit = 0; cease = 1;
    tick();
    chk("t6_state", w_t'(state), w_t'(2));
    rec_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_drained", w_t'(rec_valid), w_t'(0));
    rand_fields(); commit = 1;
    tick();
    chk("t6_drop", w_t'(drop_count), w_t'(1));
    commit = 0;
    tick();
    do_reset();
    chk("t6_reset_state", w_t'(state), w_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/insight_commit_tracker.md
# insight_commit_tracker

Downstream consumer of the per-hart Insight core monitor. Turns the monitor's single-cycle retirement events into ordered, sequence-numbered records:
- event kinds: commit, exception, interrupt;
- records are buffered in a small FIFO and drained over a valid/ready port to the riscv-dv trace logger.

The block also tracks the hart's run/WFI/cease state, keeps retirement statistics, and flags a hung hart via a no-retirement watchdog.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2
- XLEN, 32, data/PC width
- TIMEOUT, 4096, idle cycles in RUN before `hang` sets

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- commit  in  1  instruction retired this cycle
- exception  in  1  synchronous exception taken this cycle
- interrupt_fire  in  1  interrupt taken this cycle
- wfi  in  1  hart in WFI (level)
- cease  in  1  hart ceased (level)
- ev_pc  in  XLEN  PC of event
- ev_insn  in  32  instruction bits
- ev_cause  in  XLEN  mcause for exception/interrupt
- ev_wb  in  1  commit writes a GPR
- ev_rd  in  5  destination register
- ev_data  in  XLEN  writeback value
- rec_valid  out  1  record available
- rec_ready  in  1  logger accepts
- rec_kind  out  2  0=commit, 1=exception, 2=interrupt
- rec_pc, rec_insn, rec_data  out  XLEN/32/XLEN  record fields (`rec_data` = `ev_cause` for traps)
- rec_wb  out  1  record fields
- rec_rd  out  5  record fields
- rec_seq  out  32  record sequence number
- retire_count  out  64  commits accepted into FIFO
- drop_count  out  16  events lost; saturating
- overflow  out  1  sticky: any drop due to full
- collision  out  1  sticky: more than one event in one cycle
- hang  out  1  sticky watchdog flag
- state  out  2  0=RUN, 1=WFI, 2=CEASED

## Operation
Event selection:
- At most one record is pushed per cycle.
- Priority: interrupt_fire > exception > commit.
- Any losing event sets `collision` and increments `drop_count`.

Push:
- A push occurs when an event is selected, `state`≠CEASED, and the FIFO is not full.
- A push is also allowed when the FIFO is full if a pop occurs in the same cycle.
- Otherwise the event is dropped: `drop_count`++ and `overflow` sets (full case only).

Sequence and counters:
- `rec_seq` is taken from an internal counter that increments on every push, starting at 0 and wrapping at 2^32.
- `retire_count` increments on each commit push.
- For trap records, `rec_wb`=0 and `rec_rd`=0.

Pop: a pop occurs when `rec_valid && rec_ready`. Records leave in push order.

State machine:
- RUN→WFI when `wfi`=1.
- WFI→RUN when `wfi`=0.
- RUN or WFI→CEASED when `cease`=1.
- `cease` has priority over `wfi`.
- CEASED is terminal until reset.
- Events arriving while in CEASED are dropped: `drop_count`++, `collision` is unaffected.
- Records already queued before CEASED still drain.

Watchdog:
- In RUN, the counter increments on each cycle with no event and clears on any event.
- It clears on entering WFI and holds in WFI and CEASED.
- `hang` sets when the counter reaches TIMEOUT. The counter saturates there.

## Timing
- Event in cycle N: `rec_valid`=1 from cycle N+1 if the FIFO was empty. No combinational input→output path.
- `rec_*` fields are stable while `rec_valid`=1 and `rec_ready`=0.
- Counters and sticky flags update at the edge ending the event cycle. `state` updates one cycle after the `wfi`/`cease` change.
- Reset values:
  - `rec_valid`=0, `state`=RUN, all counters 0, all sticky flags 0.
  - `rec_*` data = 0.
  - FIFO emptied; sequence counter = 0.
- Reset asserted mid-operation discards queued records immediately (asynchronous).
- `drop_count` holds at 0xFFFF once saturated.

## Structure
- Shared package `insight_trace_pkg` holds:
  - `rec_kind_e` (COMMIT/EXCEPTION/INTERRUPT);
  - `hart_state_e` (RUN/WFI/CEASED);
  - `commit_rec_t` struct (kind, pc, insn, wb, rd, data, seq).
- One natural sub-module, `insight_rec_fifo`:
  - parameterised on DEPTH and the `commit_rec_t` type;
  - registered storage, read/write pointers with an extra wrap bit;
  - same-cycle push/pop when full.
- Top level contains event arbitration, the state machine, counters, and the watchdog.

## Test plan
- Single commit, `ev_pc`=0x8000_0000, `ev_rd`=5, `ev_data`=0x1234, `rec_ready`=1 → `rec_valid` next cycle with kind 0, `rec_seq`=0; `retire_count`=1.
- Commit + interrupt_fire same cycle, `ev_cause`=0x8000_0007 → one interrupt record; `collision`=1, `drop_count`=1.
- `rec_ready`=0, 10 commits with DEPTH=8 → 8 queued, `drop_count`=2, `overflow`=1. Then `rec_ready`=1 → `rec_seq` 0..7 in order.
- FIFO full, `rec_ready`=1 plus a new commit the same cycle → push accepted; `drop_count` unchanged.
- `wfi` high for 10000 cycles with TIMEOUT=4096 → `state`=WFI, `hang`=0. Then `wfi`=0 with no commits for 4096 cycles → `hang`=1.
- `cease`=1 with 3 records queued → `state`=CEASED; 3 records drain; a later commit increments `drop_count`. Reset then returns everything to reset values.
